// File: rtl/sys_array_pkg.sv
// Shared types for the systolic array path: writeback FSM states and compute-lock codes.
package sys_array_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } wb_state_t;

    // Compute-lock ownership codes used by the controller.
    localparam logic [1:0] LOCK_FREE = 2'd0;
    localparam logic [1:0] LOCK_ZERO = 2'd1;
    localparam logic [1:0] LOCK_ONE  = 2'd2;

endpackage

// File: rtl/sys_array_c_writeback_if.sv
// Result-stream / C-memory-write bundle between the systolic array side and the writeback stage.
interface sys_array_c_writeback_if
    import sys_array_pkg::*;
#(
    parameter int unsigned BITWIDTH  = 8,
    parameter int unsigned ACCWIDTH  = 32,
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned MESHUNITS = 4,
    parameter int unsigned TILEUNITS = 1
);
    logic                                               start;
    logic [ADDRWIDTH-1:0]                               C_base_addr;
    // Elements are two's-complement signed values.
    logic [MESHUNITS-1:0][TILEUNITS-1:0][ACCWIDTH-1:0]  in_c;
    logic [MESHUNITS-1:0][TILEUNITS-1:0]                in_c_valid;
    logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]  C;
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0]                C_col_write_addrs;
    logic [MESHUNITS-1:0]                               C_write_valid;
    logic                                               busy;
    logic                                               finished;
    logic                                               error;

    modport master (
        output start, C_base_addr, in_c, in_c_valid,
        input  C, C_col_write_addrs, C_write_valid, busy, finished, error
    );

    modport slave (
        input  start, C_base_addr, in_c, in_c_valid,
        output C, C_col_write_addrs, C_write_valid, busy, finished, error
    );

endinterface

// File: rtl/sys_array_delay_line.sv
// Fixed-depth data+valid delay line; valids clear on reset, DEPTH=0 is a wire.
module sys_array_delay_line #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NVALID = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [NVALID-1:0] in_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [NVALID-1:0] out_valid
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            assign out_data  = in_data;
            assign out_valid = in_valid;
        end else begin : g_pipe
            logic [WIDTH-1:0]  data_q  [DEPTH];
            logic [NVALID-1:0] valid_q [DEPTH];

            always_ff @(posedge clock) begin
                data_q[0] <= in_data;
                for (int unsigned i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) valid_q[i] <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    for (int unsigned i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
                end
            end

            assign out_data  = data_q[DEPTH-1];
            assign out_valid = valid_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sys_array_c_writeback.sv
// De-skews systolic array column outputs and writes one C row per cycle to memory.
// Define SYS_ARRAY_WB_SATURATE_EN to clamp elements instead of truncating them.
module sys_array_c_writeback
    import sys_array_pkg::*;
#(
    parameter int unsigned BITWIDTH  = 8,
    parameter int unsigned ACCWIDTH  = 32,
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned MESHUNITS = 4,
    parameter int unsigned TILEUNITS = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    sys_array_c_writeback_if.slave  bus
);

    localparam int unsigned ROWS = MESHUNITS * TILEUNITS;
    localparam int unsigned CNTW = $clog2(ROWS + 1);

    wb_state_t             state_q, state_d;
    logic [CNTW-1:0]       r_q;
    logic [ADDRWIDTH-1:0]  base_q;

    logic [MESHUNITS-1:0][TILEUNITS-1:0][ACCWIDTH-1:0] data_d;
    logic [MESHUNITS-1:0][TILEUNITS-1:0]               valid_d;
    logic [MESHUNITS-1:0]                              col_valid;
    logic tile_mismatch, row_valid, row_partial, accept, err_set;

    logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] c_q;
    logic [MESHUNITS-1:0][ADDRWIDTH-1:0]               addr_q;
    logic [MESHUNITS-1:0]                              wv_q;
    logic                                              err_q;

    function automatic logic [BITWIDTH-1:0] narrow(input logic [ACCWIDTH-1:0] x);
`ifdef SYS_ARRAY_WB_SATURATE_EN
        // In range exactly when every bit above the target sign bit copies the sign.
        if (x[ACCWIDTH-1:BITWIDTH-1] == {(ACCWIDTH-BITWIDTH+1){x[ACCWIDTH-1]}})
            return x[BITWIDTH-1:0];
        else if (x[ACCWIDTH-1])
            return {1'b1, {(BITWIDTH-1){1'b0}}};
        else
            return {1'b0, {(BITWIDTH-1){1'b1}}};
`else
        return x[BITWIDTH-1:0];
`endif
    endfunction

`ifndef SYS_ARRAY_WB_SATURATE_EN
    logic unused_acc_msbs;
    assign unused_acc_msbs = ^data_d;
`endif

    // Column j lags column 0 by j cycles, so it is held back MESHUNITS-1-j cycles.
    generate
        for (genvar j = 0; j < MESHUNITS; j++) begin : g_col
            sys_array_delay_line #(
                .DEPTH  (MESHUNITS - 1 - j),
                .WIDTH  (TILEUNITS * ACCWIDTH),
                .NVALID (TILEUNITS)
            ) u_delay (
                .clock     (clock),
                .reset     (reset),
                .in_data   (bus.in_c[j]),
                .in_valid  (bus.in_c_valid[j]),
                .out_data  (data_d[j]),
                .out_valid (valid_d[j])
            );
        end
    endgenerate

    always_comb begin
        col_valid     = '0;
        tile_mismatch = 1'b0;
        for (int unsigned j = 0; j < MESHUNITS; j++) begin
            col_valid[j] = valid_d[j][0];
            if (valid_d[j] != {TILEUNITS{valid_d[j][0]}}) tile_mismatch = 1'b1;
        end
        row_valid   = &col_valid;
        row_partial = ((|col_valid) && !row_valid) || tile_mismatch;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                base_q <= bus.C_base_addr;
                r_q    <= '0;
            end else if (accept) begin
                r_q <= r_q + 1'b1;
            end
        end
    end

    // The counter reaching ROWS marks the cycle the final row appears on the outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ACTIVE;
            ACTIVE:  if (r_q == CNTW'(ROWS)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_q == ACTIVE) && row_valid && !row_partial && (r_q != CNTW'(ROWS));
        err_set = row_partial
                || ((state_q != IDLE) && bus.start)
                || ((|bus.in_c_valid) && (((state_q == IDLE) && !bus.start) || (state_q == DONE)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            c_q    <= '0;
            addr_q <= '0;
            wv_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_q | err_set;
            wv_q  <= {MESHUNITS{accept}};
            for (int unsigned j = 0; j < MESHUNITS; j++) begin
                addr_q[j] <= accept ? base_q + ADDRWIDTH'(r_q) * ADDRWIDTH'(ROWS)
                                     + ADDRWIDTH'(j * TILEUNITS) : '0;
                if (accept) begin
                    for (int unsigned k = 0; k < TILEUNITS; k++)
                        c_q[j][k] <= narrow(data_d[j][k]);
                end
            end
        end
    end

    assign bus.C                 = c_q;
    assign bus.C_col_write_addrs = addr_q;
    assign bus.C_write_valid     = wv_q;
    assign bus.error             = err_q;
    assign bus.busy              = (state_q != IDLE);
    assign bus.finished          = (state_q == DONE);

endmodule
